// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared defaults and master state encoding for the APB subsystem
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB slave over a byte-wide register memory with optional wait states
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0]  wait_cnt_q;
  logic [CNT_W-1:0]  wait_cnt_d;

  assign pready = psel & penable & (wait_cnt_q == CNT_W'(WAIT_CYCLES));
  assign prdata = mem_q[paddr];

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!psel || pready) begin
      wait_cnt_d = '0;
    end else if (penable) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (psel && penable && pready && pwrite) begin
      mem_d[paddr] = pwdata;
    end
  end

  // Reset clears the whole array, so it also cancels a write committing on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      mem_q      <= '{default: '0};
    end else begin
      wait_cnt_q <= wait_cnt_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: rtl/apb_top.sv
// rtl/apb_top.sv - APB master bridge turning user requests into SETUP/ACCESS phases
module apb_top
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              transfer,
  input  logic              read_write,
  input  logic [ADDR_W-1:0] apb_read_add,
  input  logic [ADDR_W-1:0] apb_write_add,
  input  logic [DATA_W-1:0] apb_write_data,
  output logic [DATA_W-1:0] pr_data,
  output logic              ready
);

  apb_state_t        state_q, state_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] pr_data_q, pr_data_d;

  logic              psel;
  logic              penable;
  logic              pready;
  logic [DATA_W-1:0] prdata;

  always_comb begin
    state_d = state_q;
    psel    = 1'b0;
    penable = 1'b0;
    case (state_q)
      IDLE: begin
        if (transfer) state_d = SETUP;
      end
      SETUP: begin
        psel    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) state_d = transfer ? SETUP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request fields are sampled only on entry to SETUP and held for the whole transfer.
  always_comb begin
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    if (state_d == SETUP) begin
      pwrite_d = read_write;
      paddr_d  = read_write ? apb_write_add : apb_read_add;
      pwdata_d = apb_write_data;
    end
  end

  always_comb begin
    pr_data_d = pr_data_q;
    if (psel && penable && pready && !pwrite_q) pr_data_d = prdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pr_data_q <= pr_data_d;
    end
  end

  apb_slave_mem #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_slave (
    .clk     (clk),
    .rst     (rst),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite_q),
    .paddr   (paddr_q),
    .pwdata  (pwdata_q),
    .prdata  (prdata),
    .pready  (pready)
  );

  assign pr_data = pr_data_q;
  assign ready   = pready;

endmodule

// File: tb/tb_apb_top.sv
// tb/tb_apb_top.sv - scoreboard bench for apb_top with zero-wait and two-wait slaves
module tb_apb_top;
  import apb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, transfer0, rw0, ready0;
  logic [7:0] ra0, wa0, wd0, pr0;
  logic       rst1, transfer1, rw1, ready1;
  logic [7:0] ra1, wa1, wd1, pr1;

  apb_top #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .transfer(transfer0), .read_write(rw0),
    .apb_read_add(ra0), .apb_write_add(wa0), .apb_write_data(wd0),
    .pr_data(pr0), .ready(ready0)
  );

  apb_top #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst1), .transfer(transfer1), .read_write(rw1),
    .apb_read_add(ra1), .apb_write_add(wa1), .apb_write_data(wd1),
    .pr_data(pr1), .ready(ready1)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] last_rd0 = 8'h00;
  logic [7:0] last_rd1 = 8'h00;
  bit abort0 = 1'b0;
  bit pend0 = 1'b0, pend1 = 1'b0;
  bit prev_rdy0 = 1'b0, prev_rdy1 = 1'b0;
  logic [7:0] pexp0, pexp1;

  // Monitor: each ready pulse retires one queued expectation, checked on pr_data a cycle later.
  always @(negedge clk) begin
    if (pend0) begin
      total++;
      if (pr0 !== pexp0) begin bad++; $display("FAIL pr_data0 actual=%02h required=%02h", pr0, pexp0); end
      pend0 = 1'b0;
    end
    if (ready0) begin
      total++;
      if (prev_rdy0) begin bad++; $display("FAIL ready0_pulse actual=long required=single"); end
      if (!abort0) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL ready0_unexpected actual=pulse required=none");
        end else begin
          pexp0 = q0.pop_front();
          pend0 = 1'b1;
        end
      end
    end
    prev_rdy0 = ready0;

    if (pend1) begin
      total++;
      if (pr1 !== pexp1) begin bad++; $display("FAIL pr_data1 actual=%02h required=%02h", pr1, pexp1); end
      pend1 = 1'b0;
    end
    if (ready1) begin
      total++;
      if (prev_rdy1) begin bad++; $display("FAIL ready1_pulse actual=long required=single"); end
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL ready1_unexpected actual=pulse required=none");
      end else begin
        pexp1 = q1.pop_front();
        pend1 = 1'b1;
      end
    end
    prev_rdy1 = ready1;
  end

  task automatic drive(input int d, input bit t, input bit rw, input logic [7:0] addr, input logic [7:0] data);
    if (d == 0) begin
      transfer0 = t; rw0 = rw; wd0 = data;
      ra0 = rw ? 8'hEE : addr; wa0 = rw ? addr : 8'hEE;
    end else begin
      transfer1 = t; rw1 = rw; wd1 = data;
      ra1 = rw ? 8'hEE : addr; wa1 = rw ? addr : 8'hEE;
    end
  endtask

  // Issues one transfer starting at a negedge; returns at the negedge after the ready pulse
  // (or one cycle later, back in IDLE, when last is set).
  task automatic xfer(input int d, input bit wr, input logic [7:0] addr, input logic [7:0] data,
                      input logic [7:0] exp_rd, input bit last, input bit scramble);
    int cyc;
    bit rdy;
    int exp_cyc;
    exp_cyc = (d == 0) ? 2 : 4;
    drive(d, 1'b1, wr, addr, data);
    if (d == 0) begin
      if (!wr) last_rd0 = exp_rd;
      q0.push_back(last_rd0);
    end else begin
      if (!wr) last_rd1 = exp_rd;
      q1.push_back(last_rd1);
    end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (scramble && cyc == 1) drive(d, 1'b1, ~wr, ~addr, ~data);
      rdy = (d == 0) ? ready0 : ready1;
    end while (!rdy && cyc < 20);
    total++;
    if (!rdy || cyc != exp_cyc) begin
      bad++;
      $display("FAIL latency d%0d addr=%02h actual=%0d required=%0d", d, addr, rdy ? cyc : -1, exp_cyc);
    end
    if (last) begin
      if (d == 0) transfer0 = 1'b0; else transfer1 = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin bad++; $display("FAIL %s actual=%02h required=%02h", name, act, req); end
  endtask

  initial begin
    int cyc;
    rst0 = 1'b1; rst1 = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    check8("reset_pr_data0", pr0, 8'h00);
    check8("reset_ready0", {7'd0, ready0}, 8'h00);
    check8("reset_state0", {6'd0, dut0.state_q}, {6'd0, IDLE});
    check8("reset_pr_data1", pr1, 8'h00);
    @(negedge clk);

    // Reads after reset return zero.
    xfer(0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    xfer(0, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);

    // Single write then read back.
    xfer(0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b1, 1'b0);
    xfer(0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b1, 1'b0);

    // Back-to-back: writes then reads with transfer held high.
    xfer(0, 1'b1, 8'h20, 8'h01, 8'h00, 1'b0, 1'b0);
    xfer(0, 1'b1, 8'h21, 8'h02, 8'h00, 1'b0, 1'b0);
    xfer(0, 1'b0, 8'h20, 8'h00, 8'h01, 1'b0, 1'b0);
    xfer(0, 1'b0, 8'h21, 8'h00, 8'h02, 1'b0, 1'b0);
    xfer(0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b1, 1'b0);

    // Inputs changed mid-transfer must not disturb the captured request.
    xfer(0, 1'b1, 8'h55, 8'h3C, 8'h00, 1'b1, 1'b1);
    xfer(0, 1'b0, 8'h55, 8'h00, 8'h3C, 1'b1, 1'b0);
    xfer(0, 1'b0, 8'hAA, 8'h00, 8'h00, 1'b1, 1'b0);

    // Two wait states: ready only on the third ACCESS cycle; one commit.
    xfer(1, 1'b1, 8'h40, 8'h5A, 8'h00, 1'b1, 1'b1);
    xfer(1, 1'b0, 8'h40, 8'h00, 8'h5A, 1'b0, 1'b1);
    xfer(1, 1'b0, 8'hBF, 8'h00, 8'h00, 1'b1, 1'b0);

    // Reset during the ACCESS of a write: nothing commits.
    xfer(0, 1'b1, 8'h30, 8'h11, 8'h00, 1'b1, 1'b0);
    abort0 = 1'b1;
    drive(0, 1'b1, 1'b1, 8'h30, 8'h77);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!ready0 && cyc < 20);
    total++;
    if (!ready0) begin bad++; $display("FAIL abort_access actual=timeout required=ready"); end
    rst0 = 1'b1;
    transfer0 = 1'b0;
    @(negedge clk);
    rst0 = 1'b0;
    abort0 = 1'b0;
    last_rd0 = 8'h00;
    check8("abort_state0", {6'd0, dut0.state_q}, {6'd0, IDLE});
    check8("abort_ready0", {7'd0, ready0}, 8'h00);
    check8("abort_pr_data0", pr0, 8'h00);
    xfer(0, 1'b0, 8'h30, 8'h00, 8'h00, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL queue_drain actual=%0d/%0d required=0/0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
